// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed active-low seven-segment scan driver with a frame-synchronous shadow register.
// Optional leading-zero blanking when SEG_LEAD_BLANK_EN is defined. Rev 1.0
`default_nettype none

module seg7_scan_driver #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 2
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  input  logic                scan_tick,
  input  logic                upd_req,
  input  logic [4*DIGITS-1:0] upd_value,
  input  logic [DIGITS-1:0]   upd_dp,
  output logic                upd_ack,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                frame_start
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;

  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic [4*DIGITS-1:0] val_q;
  logic [4*DIGITS-1:0] val_nxt;
  logic [DIGITS-1:0]   dpm_q;
  logic [DIGITS-1:0]   dpm_nxt;
  logic                boundary;
  logic                load;
  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   an_nxt;
  logic [6:0]          seg_nxt;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = SEG_OFF;
    endcase
    return g;
  endfunction

  // Shadow loads on the wrap tick, and the new digit 0 decodes from the freshly loaded data.
  assign boundary = scan_tick && (idx == LAST_IDX);
  assign load     = boundary && upd_req;
  assign idx_nxt  = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  assign val_nxt  = load ? upd_value : val_q;
  assign dpm_nxt  = load ? upd_dp : dpm_q;

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_nib
      assign nib[k] = val_nxt[4*k +: 4];
    end
  endgenerate

  always_comb begin
    an_nxt = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) an_nxt[i] = 1'b0;
    end
  end

`ifdef SEG_LEAD_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              seen;

  // Walk from the most significant digit; a nonzero nibble or lit dp stops blanking below it.
  always_comb begin
    seen  = 1'b0;
    blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seen     = seen | (nib[k] != 4'h0) | dpm_nxt[k];
      blank[k] = (k != 0) && !seen;
    end
  end

  assign seg_nxt = blank[idx_nxt] ? SEG_OFF : hex_glyph(nib[idx_nxt]);
`else
  assign seg_nxt = hex_glyph(nib[idx_nxt]);
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      idx         <= '0;
      val_q       <= '0;
      dpm_q       <= '0;
      an          <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      upd_ack     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      upd_ack     <= load;
      frame_start <= boundary;
      if (scan_tick) begin
        idx   <= idx_nxt;
        val_q <= val_nxt;
        dpm_q <= dpm_nxt;
        an    <= an_nxt;
        seg   <= seg_nxt;
        dp    <= ~dpm_nxt[idx_nxt];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: random scan/handshake traffic compared against a digit-level display model.
`default_nettype none

module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int IDX_W  = 2;

  logic                CLOCK = 1'b0;
  logic                RESET_N = 1'b1;
  logic                scan_tick = 1'b0;
  logic                upd_req = 1'b0;
  logic [4*DIGITS-1:0] upd_value = '0;
  logic [DIGITS-1:0]   upd_dp = '0;
  logic                upd_ack;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                dp;
  logic                frame_start;

  seg7_scan_driver #(.DIGITS(DIGITS), .IDX_W(IDX_W)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .scan_tick(scan_tick), .upd_req(upd_req),
    .upd_value(upd_value), .upd_dp(upd_dp), .upd_ack(upd_ack), .an(an), .seg(seg),
    .dp(dp), .frame_start(frame_start)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: which digit is lit, what the display holds, and the pulses owed this cycle.
  int              m_idx;
  logic [15:0]     m_val;
  logic [3:0]      m_dp;
  logic [3:0]      exp_an;
  logic [6:0]      exp_seg;
  logic            exp_dp;
  logic            exp_ack;
  logic            exp_frame;

  task automatic model_reset();
    m_idx = 0; m_val = '0; m_dp = '0;
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ack = 1'b0; exp_frame = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] n;
    exp_ack = 1'b0;
    exp_frame = 1'b0;
    if (scan_tick) begin
      if (m_idx == DIGITS - 1) begin
        exp_frame = 1'b1;
        if (upd_req) begin
          m_val = upd_value; m_dp = upd_dp; exp_ack = 1'b1;
        end
      end
      m_idx   = (m_idx + 1) % DIGITS;
      exp_an  = 4'hF ^ 4'(1 << m_idx);
      n       = 4'((m_val >> (4 * m_idx)) & 16'hF);
      exp_seg = glyph[n];
`ifdef SEG_LEAD_BLANK_EN
      if (m_idx != 0 && (m_val >> (4 * m_idx)) == 0 && (m_dp >> m_idx) == 0) exp_seg = 7'h7F;
`endif
      exp_dp  = ~m_dp[m_idx];
    end
  endtask

  task automatic check_outputs(input string phase);
    check({phase, ".an"},    32'(an),          32'(exp_an));
    check({phase, ".seg"},   32'(seg),         32'(exp_seg));
    check({phase, ".dp"},    32'(dp),          32'(exp_dp));
    check({phase, ".ack"},   32'(upd_ack),     32'(exp_ack));
    check({phase, ".frame"}, 32'(frame_start), 32'(exp_frame));
  endtask

  initial begin
    logic [15:0] mask;
    #2 RESET_N = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    repeat (2) @(posedge CLOCK);
    #1 RESET_N = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      @(posedge CLOCK);
      #1;
      model_step();
      check_outputs("scan");

      scan_tick = ($urandom_range(0, 2) == 0);
      if (upd_req) begin
        if (exp_ack || $urandom_range(0, 59) == 0) upd_req = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        mask      = 16'hFFFF >> (4 * $urandom_range(0, 3));
        upd_req   = 1'b1;
        upd_value = 16'($urandom) & mask;
        upd_dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      end

      if (c == 1500 || c == 3100) begin
        #3 RESET_N = 1'b0;
        #1;
        model_reset();
        check_outputs("midreset");
        upd_req   = 1'b0;
        scan_tick = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1 RESET_N = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
